control_unit: RTL and testbench

Hardwired Moore-style sequencer for the 32-bit datapath. It drives the bus-enable, register-load, memory and register-select control lines, one state per clock. It fetches an instruction, decodes opcode IR[31:27], and steps through that instruction's T-states. It sits directly upstream of `Datapath` and replaces the hand-written stimulus currently used to step instructions through it.

---
 rtl/cpu_defs.sv | 116 +++++++++++
 rtl/ctrl_decode.sv | 112 +++++++++++
 rtl/control_unit.sv | 143 ++++++++++++++
 tb/tb_control_unit.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_defs.sv
// Shared CPU definitions: opcodes, controller state encoding, control-vector layout.
// Build option CTRL_BRANCH_EN: when undefined the br opcode is classified as a nop.
package cpu_defs;

  localparam int OPCODE_W = 5;

  localparam logic [4:0] OP_LD   = 5'd0;
  localparam logic [4:0] OP_LDI  = 5'd1;
  localparam logic [4:0] OP_ST   = 5'd2;
  localparam logic [4:0] OP_ADD  = 5'd3;
  localparam logic [4:0] OP_SUB  = 5'd4;
  localparam logic [4:0] OP_AND  = 5'd5;
  localparam logic [4:0] OP_OR   = 5'd6;
  localparam logic [4:0] OP_SHR  = 5'd7;
  localparam logic [4:0] OP_SHRA = 5'd8;
  localparam logic [4:0] OP_SHL  = 5'd9;
  localparam logic [4:0] OP_ROR  = 5'd10;
  localparam logic [4:0] OP_ROL  = 5'd11;
  localparam logic [4:0] OP_ADDI = 5'd12;
  localparam logic [4:0] OP_ANDI = 5'd13;
  localparam logic [4:0] OP_ORI  = 5'd14;
  localparam logic [4:0] OP_BR   = 5'd18;
  localparam logic [4:0] OP_JR   = 5'd20;
  localparam logic [4:0] OP_NOP  = 5'd26;
  localparam logic [4:0] OP_HALT = 5'd27;

  typedef enum logic [3:0] {
    S_RST  = 4'd0,
    S_T0   = 4'd1,
    S_T1   = 4'd2,
    S_T2   = 4'd3,
    S_T3   = 4'd4,
    S_T4   = 4'd5,
    S_T5   = 4'd6,
    S_T6   = 4'd7,
    S_T7   = 4'd8,
    S_HALT = 4'd9
  } state_t;

  typedef enum logic [3:0] {
    IC_LD   = 4'd0,
    IC_LDI  = 4'd1,
    IC_ST   = 4'd2,
    IC_ALU  = 4'd3,
    IC_IMM  = 4'd4,
    IC_BR   = 4'd5,
    IC_JR   = 4'd6,
    IC_NOP  = 4'd7,
    IC_HALT = 4'd8
  } iclass_t;

  typedef struct packed {
    logic pc_out;
    logic zlow_out;
    logic zhi_out;
    logic mdr_out;
    logic hi_out;
    logic lo_out;
    logic c_out;
    logic inport_out;
    logic r_out;
    logic ba_out;
    logic pc_in;
    logic ir_in;
    logic mar_in;
    logic mdr_in;
    logic y_in;
    logic z_in;
    logic hi_in;
    logic lo_in;
    logic r_in;
    logic con_in;
    logic outport_in;
    logic inc_pc;
    logic read;
    logic write;
    logic gra;
    logic grb;
    logic grc;
  } ctrl_t;

  // Undefined opcodes fall into the nop class.
  function automatic iclass_t classify(input logic [4:0] op);
    iclass_t ic;
    case (op)
      OP_LD:   ic = IC_LD;
      OP_LDI:  ic = IC_LDI;
      OP_ST:   ic = IC_ST;
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHRA,
      OP_SHL, OP_ROR, OP_ROL:
               ic = IC_ALU;
      OP_ADDI, OP_ANDI, OP_ORI:
               ic = IC_IMM;
`ifdef CTRL_BRANCH_EN
      OP_BR:   ic = IC_BR;
`endif
      OP_JR:   ic = IC_JR;
      OP_HALT: ic = IC_HALT;
      default: ic = IC_NOP;
    endcase
    return ic;
  endfunction

  function automatic state_t last_state(input iclass_t ic);
    state_t s;
    case (ic)
      IC_LD, IC_ST:           s = S_T7;
      IC_BR:                  s = S_T6;
      IC_LDI, IC_ALU, IC_IMM: s = S_T5;
      IC_JR:                  s = S_T3;
      default:                s = S_T2;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational map from (state, instruction class, CON_FF) to the control vector.
// Build option CTRL_BRANCH_EN: enables the br T-states, CONin and conditional PCin.
module ctrl_decode
  import cpu_defs::*;
(
  input  state_t  state,
  input  iclass_t iclass,
  input  logic    con_ff,
  output ctrl_t   ctrl
);

`ifndef CTRL_BRANCH_EN
  logic unused_con_ff_s;
  assign unused_con_ff_s = con_ff;
`endif

  // Control lines for each state; fetch is shared, T3 onward depends on the class.
  always_comb begin
    ctrl = '0;
    case (state)
      S_T0: begin
        ctrl.pc_out = 1'b1; ctrl.mar_in = 1'b1; ctrl.inc_pc = 1'b1; ctrl.z_in = 1'b1;
      end
      S_T1: begin
        ctrl.zlow_out = 1'b1; ctrl.pc_in = 1'b1; ctrl.read = 1'b1; ctrl.mdr_in = 1'b1;
      end
      S_T2: begin
        ctrl.mdr_out = 1'b1; ctrl.ir_in = 1'b1;
      end
      S_T3: begin
        case (iclass)
          IC_LD, IC_LDI, IC_ST: begin
            ctrl.grb = 1'b1; ctrl.ba_out = 1'b1; ctrl.y_in = 1'b1;
          end
          IC_ALU, IC_IMM: begin
            ctrl.grb = 1'b1; ctrl.r_out = 1'b1; ctrl.y_in = 1'b1;
          end
`ifdef CTRL_BRANCH_EN
          IC_BR: begin
            ctrl.gra = 1'b1; ctrl.r_out = 1'b1; ctrl.con_in = 1'b1;
          end
`endif
          IC_JR: begin
            ctrl.gra = 1'b1; ctrl.r_out = 1'b1; ctrl.pc_in = 1'b1;
          end
          default: ;
        endcase
      end
      S_T4: begin
        case (iclass)
          IC_LD, IC_LDI, IC_ST, IC_IMM: begin
            ctrl.c_out = 1'b1; ctrl.z_in = 1'b1;
          end
          IC_ALU: begin
            ctrl.grc = 1'b1; ctrl.r_out = 1'b1; ctrl.z_in = 1'b1;
          end
`ifdef CTRL_BRANCH_EN
          IC_BR: begin
            ctrl.pc_out = 1'b1; ctrl.y_in = 1'b1;
          end
`endif
          default: ;
        endcase
      end
      S_T5: begin
        case (iclass)
          IC_LD, IC_ST: begin
            ctrl.zlow_out = 1'b1; ctrl.mar_in = 1'b1;
          end
          IC_LDI, IC_ALU, IC_IMM: begin
            ctrl.zlow_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1;
          end
`ifdef CTRL_BRANCH_EN
          IC_BR: begin
            ctrl.c_out = 1'b1; ctrl.z_in = 1'b1;
          end
`endif
          default: ;
        endcase
      end
      S_T6: begin
        case (iclass)
          IC_LD: begin
            ctrl.read = 1'b1; ctrl.mdr_in = 1'b1;
          end
          IC_ST: begin
            ctrl.gra = 1'b1; ctrl.r_out = 1'b1; ctrl.mdr_in = 1'b1;
          end
`ifdef CTRL_BRANCH_EN
          IC_BR: begin
            ctrl.zlow_out = 1'b1; ctrl.pc_in = con_ff;
          end
`endif
          default: ;
        endcase
      end
      S_T7: begin
        case (iclass)
          IC_LD: begin
            ctrl.mdr_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1;
          end
          IC_ST: begin
            ctrl.write = 1'b1;
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Hardwired sequencer: holds state and latched opcode, steps T-states, registers the
// control vector so every output is a flop. Optional br support: see CTRL_BRANCH_EN.
module control_unit
  import cpu_defs::*;
#(
  parameter int OPW = 5
) (
  input  logic        Clock,
  input  logic        Clear,
  input  logic [31:0] IR,
  input  logic        CON_FF,
  input  logic        Stop,
  output logic        Run,
  output logic        PCout,
  output logic        Zlowout,
  output logic        Zhiout,
  output logic        MDRout,
  output logic        HIout,
  output logic        LOout,
  output logic        Cout,
  output logic        InPortout,
  output logic        Rout,
  output logic        BAout,
  output logic        PCin,
  output logic        IRin,
  output logic        MARin,
  output logic        MDRin,
  output logic        Yin,
  output logic        Zin,
  output logic        HIin,
  output logic        LOin,
  output logic        Rin,
  output logic        CONin,
  output logic        Out_Portin,
  output logic        IncPC,
  output logic        Read,
  output logic        Write,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc
);

  state_t         state_r;
  state_t         next_state_s;
  logic [OPW-1:0] opcode_r;
  logic [OPW-1:0] next_opcode_s;
  iclass_t        iclass_s;
  ctrl_t          ctrl_next_s;
  ctrl_t          ctrl_r;
  logic           run_r;
  logic           unused_ir_s;

  assign unused_ir_s = ^IR[31-OPW:0];

  // The opcode is captured on the T2->T3 edge; later states use only the latched copy.
  always_comb begin
    if (state_r == S_T2) begin
      next_opcode_s = IR[31 -: OPW];
    end else begin
      next_opcode_s = opcode_r;
    end
  end

  assign iclass_s = classify(next_opcode_s);

  // Next state: advance one T-state, leave at the class's final state; Stop only counts there.
  always_comb begin
    next_state_s = state_r;
    if (state_r == last_state(iclass_s)) begin
      if ((iclass_s == IC_HALT) || Stop) begin
        next_state_s = S_HALT;
      end else begin
        next_state_s = S_T0;
      end
    end else begin
      case (state_r)
        S_RST:   next_state_s = S_T0;
        S_T0:    next_state_s = S_T1;
        S_T1:    next_state_s = S_T2;
        S_T2:    next_state_s = S_T3;
        S_T3:    next_state_s = S_T4;
        S_T4:    next_state_s = S_T5;
        S_T5:    next_state_s = S_T6;
        S_T6:    next_state_s = S_T7;
        S_T7:    next_state_s = S_T0;
        S_HALT:  next_state_s = S_HALT;
        default: next_state_s = S_RST;
      endcase
    end
  end

  ctrl_decode u_decode (
    .state  (next_state_s),
    .iclass (iclass_s),
    .con_ff (CON_FF),
    .ctrl   (ctrl_next_s)
  );

  // State, opcode and the decoded outputs for the state being entered; Clear zeroes all.
  always_ff @(posedge Clock or posedge Clear) begin
    if (Clear) begin
      state_r  <= S_RST;
      opcode_r <= '0;
      ctrl_r   <= '0;
      run_r    <= 1'b0;
    end else begin
      state_r  <= next_state_s;
      opcode_r <= next_opcode_s;
      ctrl_r   <= ctrl_next_s;
      run_r    <= (next_state_s != S_RST) && (next_state_s != S_HALT);
    end
  end

  assign Run        = run_r;
  assign PCout      = ctrl_r.pc_out;
  assign Zlowout    = ctrl_r.zlow_out;
  assign Zhiout     = ctrl_r.zhi_out;
  assign MDRout     = ctrl_r.mdr_out;
  assign HIout      = ctrl_r.hi_out;
  assign LOout      = ctrl_r.lo_out;
  assign Cout       = ctrl_r.c_out;
  assign InPortout  = ctrl_r.inport_out;
  assign Rout       = ctrl_r.r_out;
  assign BAout      = ctrl_r.ba_out;
  assign PCin       = ctrl_r.pc_in;
  assign IRin       = ctrl_r.ir_in;
  assign MARin      = ctrl_r.mar_in;
  assign MDRin      = ctrl_r.mdr_in;
  assign Yin        = ctrl_r.y_in;
  assign Zin        = ctrl_r.z_in;
  assign HIin       = ctrl_r.hi_in;
  assign LOin       = ctrl_r.lo_in;
  assign Rin        = ctrl_r.r_in;
  assign CONin      = ctrl_r.con_in;
  assign Out_Portin = ctrl_r.outport_in;
  assign IncPC      = ctrl_r.inc_pc;
  assign Read       = ctrl_r.read;
  assign Write      = ctrl_r.write;
  assign Gra        = ctrl_r.gra;
  assign Grb        = ctrl_r.grb;
  assign Grc        = ctrl_r.grc;

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: per-instruction expected step tables built from
// the instruction rules, compared every cycle at the falling edge.
module tb_control_unit;

`ifdef CTRL_BRANCH_EN
  localparam bit BR_EN = 1'b1;
`else
  localparam bit BR_EN = 1'b0;
`endif

  // Bit positions follow the packing in act_vec().
  localparam logic [26:0] M_PCOUT  = 27'd1 << 26;
  localparam logic [26:0] M_ZLOW   = 27'd1 << 25;
  localparam logic [26:0] M_MDROUT = 27'd1 << 23;
  localparam logic [26:0] M_COUT   = 27'd1 << 20;
  localparam logic [26:0] M_ROUT   = 27'd1 << 18;
  localparam logic [26:0] M_BAOUT  = 27'd1 << 17;
  localparam logic [26:0] M_PCIN   = 27'd1 << 16;
  localparam logic [26:0] M_IRIN   = 27'd1 << 15;
  localparam logic [26:0] M_MARIN  = 27'd1 << 14;
  localparam logic [26:0] M_MDRIN  = 27'd1 << 13;
  localparam logic [26:0] M_YIN    = 27'd1 << 12;
  localparam logic [26:0] M_ZIN    = 27'd1 << 11;
  localparam logic [26:0] M_RIN    = 27'd1 << 8;
  localparam logic [26:0] M_CONIN  = 27'd1 << 7;
  localparam logic [26:0] M_INCPC  = 27'd1 << 5;
  localparam logic [26:0] M_READ   = 27'd1 << 4;
  localparam logic [26:0] M_WRITE  = 27'd1 << 3;
  localparam logic [26:0] M_GRA    = 27'd1 << 2;
  localparam logic [26:0] M_GRB    = 27'd1 << 1;
  localparam logic [26:0] M_GRC    = 27'd1 << 0;
  localparam logic [26:0] BUS_MASK = 27'h7FE0000;

  logic        Clock = 1'b0;
  logic        Clear = 1'b1;
  logic [31:0] IR = 32'd0;
  logic        CON_FF = 1'b0;
  logic        Stop = 1'b0;
  logic Run, PCout, Zlowout, Zhiout, MDRout, HIout, LOout, Cout, InPortout, Rout, BAout;
  logic PCin, IRin, MARin, MDRin, Yin, Zin, HIin, LOin, Rin, CONin, Out_Portin;
  logic IncPC, Read, Write, Gra, Grb, Grc;

  control_unit dut (
    .Clock(Clock), .Clear(Clear), .IR(IR), .CON_FF(CON_FF), .Stop(Stop), .Run(Run),
    .PCout(PCout), .Zlowout(Zlowout), .Zhiout(Zhiout), .MDRout(MDRout), .HIout(HIout),
    .LOout(LOout), .Cout(Cout), .InPortout(InPortout), .Rout(Rout), .BAout(BAout),
    .PCin(PCin), .IRin(IRin), .MARin(MARin), .MDRin(MDRin), .Yin(Yin), .Zin(Zin),
    .HIin(HIin), .LOin(LOin), .Rin(Rin), .CONin(CONin), .Out_Portin(Out_Portin),
    .IncPC(IncPC), .Read(Read), .Write(Write), .Gra(Gra), .Grb(Grb), .Grc(Grc)
  );

  always #5 Clock = ~Clock;

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [26:0] exp_q[$];
  bit          exp_halt;
  logic [26:0] exp_vec = 27'd0;
  bit          exp_run = 1'b0;
  bit          exp_valid = 1'b0;
  int          cur_op = 0;
  int          cur_step = 0;

  function automatic logic [26:0] act_vec();
    return {PCout, Zlowout, Zhiout, MDRout, HIout, LOout, Cout, InPortout, Rout, BAout,
            PCin, IRin, MARin, MDRin, Yin, Zin, HIin, LOin, Rin, CONin, Out_Portin,
            IncPC, Read, Write, Gra, Grb, Grc};
  endfunction

  task automatic check_outputs(input logic [26:0] want, input bit want_run, input string tag);
    logic [26:0] got;
    got = act_vec();
    total_cnt++;
    if (got === want) pass_cnt++;
    else $display("FAIL %s_ctrl op=%0d step=%0d got=%h want=%h", tag, cur_op, cur_step, got, want);
    total_cnt++;
    if (Run === want_run) pass_cnt++;
    else $display("FAIL %s_run op=%0d step=%0d got=%b want=%b", tag, cur_op, cur_step, Run, want_run);
    total_cnt++;
    if ($countones(got & BUS_MASK) <= 1) pass_cnt++;
    else $display("FAIL %s_bus op=%0d step=%0d drivers=%0d want<=1", tag, cur_op, cur_step,
                  $countones(got & BUS_MASK));
  endtask

  task automatic pin(input string name, input int got, input int want);
    total_cnt++;
    if (got == want) pass_cnt++;
    else $display("FAIL pin_%s got=%0d want=%0d", name, got, want);
  endtask

  // Reference model: the full per-cycle control table for one instruction, fetch included.
  task automatic build_steps(input logic [4:0] op, input logic con);
    int o;
    o = int'(op);
    exp_q = {};
    exp_halt = 1'b0;
    exp_q.push_back(M_PCOUT | M_MARIN | M_INCPC | M_ZIN);
    exp_q.push_back(M_ZLOW | M_PCIN | M_READ | M_MDRIN);
    exp_q.push_back(M_MDROUT | M_IRIN);
    if (o <= 2) begin
      exp_q.push_back(M_GRB | M_BAOUT | M_YIN);
      exp_q.push_back(M_COUT | M_ZIN);
      if (o == 1) begin
        exp_q.push_back(M_ZLOW | M_GRA | M_RIN);
      end else begin
        exp_q.push_back(M_ZLOW | M_MARIN);
        if (o == 0) begin
          exp_q.push_back(M_READ | M_MDRIN);
          exp_q.push_back(M_MDROUT | M_GRA | M_RIN);
        end else begin
          exp_q.push_back(M_GRA | M_ROUT | M_MDRIN);
          exp_q.push_back(M_WRITE);
        end
      end
    end else if (o <= 14) begin
      exp_q.push_back(M_GRB | M_ROUT | M_YIN);
      exp_q.push_back((o <= 11) ? (M_GRC | M_ROUT | M_ZIN) : (M_COUT | M_ZIN));
      exp_q.push_back(M_ZLOW | M_GRA | M_RIN);
    end else if (o == 18 && BR_EN) begin
      exp_q.push_back(M_GRA | M_ROUT | M_CONIN);
      exp_q.push_back(M_PCOUT | M_YIN);
      exp_q.push_back(M_COUT | M_ZIN);
      exp_q.push_back(con ? (M_ZLOW | M_PCIN) : M_ZLOW);
    end else if (o == 20) begin
      exp_q.push_back(M_GRA | M_ROUT | M_PCIN);
    end else if (o == 27) begin
      exp_halt = 1'b1;
    end
  endtask

  // Compare process: checks the expectation published for the current cycle.
  always @(negedge Clock) begin
    if (exp_valid) check_outputs(exp_vec, exp_run, "cycle");
  end

  task automatic do_clear();
    Clear = 1'b1;
    #1;
    cur_step = -1;
    check_outputs(27'd0, 1'b0, "clear_async");
    exp_vec = 27'd0; exp_run = 1'b0; exp_valid = 1'b1;
    @(posedge Clock); #1;
    Clear = 1'b0;
    Stop = 1'b0;
  endtask

  task automatic run_instr(input logic [4:0] op, input logic con, input logic stop_last,
                           input logic abort);
    int n;
    build_steps(op, con);
    n = exp_q.size();
    cur_op = int'(op);
    for (int k = 0; k < n; k++) begin
      @(posedge Clock); #1;
      cur_step = k;
      exp_vec = exp_q[k]; exp_run = 1'b1;
      if (k == 0) begin
        IR = {op, 27'($urandom)};
        CON_FF = con;
      end else if (k >= 3) begin
        IR = $urandom;
      end
      Stop = (k == n - 1) ? stop_last : 1'($urandom_range(0, 1));
    end
    if (abort && op == 5'd2) begin
      @(negedge Clock); #2;
      do_clear();
    end else if (exp_halt || stop_last) begin
      for (int h = 0; h < 20; h++) begin
        @(posedge Clock); #1;
        cur_step = 100 + h;
        exp_vec = 27'd0; exp_run = 1'b0;
        Stop = 1'($urandom_range(0, 1));
      end
      do_clear();
    end
  endtask

  initial begin
    // Hand-computed pins on the model's tables.
    build_steps(5'd0, 1'b0);  pin("ld_len", exp_q.size(), 8);
    pin("ld_t6", int'(exp_q[6]), int'(27'h0002010));
    build_steps(5'd2, 1'b0);  pin("st_len", exp_q.size(), 8);
    pin("st_t7", int'(exp_q[7]), int'(27'h0000008));
    build_steps(5'd18, 1'b1); pin("br_len", exp_q.size(), BR_EN ? 7 : 3);
    build_steps(5'd20, 1'b0); pin("jr_len", exp_q.size(), 4);
    build_steps(5'd3, 1'b0);  pin("add_len", exp_q.size(), 6);
    build_steps(5'd26, 1'b0); pin("nop_len", exp_q.size(), 3);
    pin("t0_vec", int'(exp_q[0]), int'(27'h4004820));

    repeat (2) @(posedge Clock);
    do_clear();
    run_instr(5'd0, 1'b0, 1'b0, 1'b0);   // ld, IR=0x00800000 class
    run_instr(5'd2, 1'b0, 1'b0, 1'b0);   // st
    run_instr(5'd2, 1'b0, 1'b0, 1'b1);   // st with Clear in T7
    run_instr(5'd18, 1'b0, 1'b0, 1'b0);  // br not taken
    run_instr(5'd18, 1'b1, 1'b0, 1'b0);  // br taken
    run_instr(5'd3, 1'b0, 1'b1, 1'b0);   // add then Stop
    run_instr(5'd31, 1'b0, 1'b0, 1'b0);  // undefined
    run_instr(5'd1, 1'b0, 1'b0, 1'b0);
    run_instr(5'd13, 1'b0, 1'b0, 1'b0);
    run_instr(5'd20, 1'b0, 1'b0, 1'b0);
    run_instr(5'd26, 1'b0, 1'b1, 1'b0);  // nop then Stop
    run_instr(5'd27, 1'b0, 1'b0, 1'b0);  // halt
    for (int i = 0; i < 150; i++) begin
      run_instr(5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                ($urandom_range(0, 9) == 0), ($urandom_range(0, 3) == 0));
    end
    @(posedge Clock); #1;
    exp_valid = 1'b0;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
